// File: rtl/multichannel_window_energy.sv
// Sliding-window energy detector for time-multiplexed multi-channel samples.
// Each sample is biased, saturated, squared and folded into a per-channel running window sum.
module multichannel_window_energy #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ENERGY_WIDTH = 32,
  parameter int CHANNELS     = 2,
  parameter int DEPTH_LOG2   = 4,
  parameter int HOP          = 1,
  parameter int SIGNAL_BIAS  = -32,
  parameter int MEAN_MODE    = 0,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_data,
  input  logic [CH_W-1:0]                sample_channel,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic [ENERGY_WIDTH-1:0]        energy_data,
  output logic [CH_W-1:0]                energy_channel,
  output logic                           energy_saturated,
  output logic                           energy_valid,
  input  logic                           energy_ready,
  output logic [1:0]                     debug_state
);

  localparam int SQ_W   = 2 * SAMPLE_WIDTH;
  localparam int SUM_W  = SQ_W + DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam int ADDR_W = CH_W + DEPTH_LOG2;
  localparam int WIDE   = (SUM_W > ENERGY_WIDTH) ? SUM_W : ENERGY_WIDTH;
  localparam logic [FILL_W-1:0] DEPTH     = FILL_W'(1 << DEPTH_LOG2);
  localparam logic [FILL_W-1:0] HOP_LAST  = FILL_W'(HOP - 1);
  localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(CHANNELS);
  localparam logic [WIDE-1:0]   E_MAX     = WIDE'({ENERGY_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, SQUARE, UPDATE, EMIT} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid source holds its data stable until that edge.
  state_t state, state_next;

  logic signed [SAMPLE_WIDTH-1:0] data_q;
  logic [CH_W-1:0]                ch_q;
  logic [SQ_W-1:0]                sq_q;
  logic [SQ_W-1:0]                old_q;
  logic [SUM_W-1:0]               new_sum_q;
  logic [SUM_W-1:0]               sum_r  [CHANNELS];
  logic [FILL_W-1:0]              fill_r [CHANNELS];
  logic [FILL_W-1:0]              hop_r  [CHANNELS];
  logic [DEPTH_LOG2-1:0]          ptr_r  [CHANNELS];
  logic [SQ_W-1:0]                ram    [2**ADDR_W];

  logic                           accept, ch_ok, slot_free;
  logic signed [SAMPLE_WIDTH:0]   biased_wide;
  logic signed [SAMPLE_WIDTH-1:0] biased;
  logic signed [SQ_W-1:0]         product;
  logic [SQ_W-1:0]                old_val;
  logic [SUM_W-1:0]               new_sum, scaled;
  logic [FILL_W-1:0]              fill_next;
  logic                           emit_due, over;
  logic [WIDE-1:0]                wide_val;
  logic [ADDR_W-1:0]              ram_addr;

  assign debug_state = state;
  assign accept      = (state == IDLE) && sample_valid && sample_ready;
  assign ch_ok       = {1'b0, sample_channel} < CH_LIMIT;
  assign slot_free   = !energy_valid || energy_ready;
  assign ram_addr    = {ch_q, ptr_r[ch_q]};

  always_comb begin
    biased_wide = {data_q[SAMPLE_WIDTH-1], data_q} + (SAMPLE_WIDTH + 1)'(SIGNAL_BIAS);
    biased      = biased_wide[SAMPLE_WIDTH-1:0];
    if (biased_wide[SAMPLE_WIDTH] != biased_wide[SAMPLE_WIDTH-1])
      biased = biased_wide[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                         : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    product = SQ_W'(biased) * SQ_W'(biased);
  end

  // Slots not yet written since reset read as zero until the window is full.
  always_comb begin
    old_val   = (fill_r[ch_q] == DEPTH) ? old_q : '0;
    new_sum   = sum_r[ch_q] + SUM_W'(sq_q) - SUM_W'(old_val);
    fill_next = (fill_r[ch_q] == DEPTH) ? fill_r[ch_q] : fill_r[ch_q] + FILL_W'(1);
    emit_due  = (fill_next == DEPTH) &&
                ((fill_r[ch_q] == DEPTH - FILL_W'(1)) || (hop_r[ch_q] == HOP_LAST));
    scaled    = (MEAN_MODE != 0) ? (new_sum_q >> DEPTH_LOG2) : new_sum_q;
    wide_val  = WIDE'(scaled);
    over      = wide_val > E_MAX;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && ch_ok) state_next = SQUARE;
      SQUARE:  state_next = UPDATE;
      UPDATE:  state_next = emit_due ? EMIT : IDLE;
      EMIT:    if (slot_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sample_ready     <= 1'b0;
      data_q           <= '0;
      ch_q             <= '0;
      sq_q             <= '0;
      new_sum_q        <= '0;
      energy_data      <= '0;
      energy_channel   <= '0;
      energy_saturated <= 1'b0;
      energy_valid     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sum_r[i]  <= '0;
        fill_r[i] <= '0;
        hop_r[i]  <= '0;
        ptr_r[i]  <= '0;
      end
    end else begin
      // An out-of-range channel is consumed and dropped, costing one ready-low cycle.
      sample_ready <= (state_next == IDLE) && !(accept && !ch_ok);
      case (state)
        IDLE: if (accept && ch_ok) begin
          data_q <= sample_data;
          ch_q   <= sample_channel;
        end
        SQUARE: sq_q <= $unsigned(product);
        UPDATE: begin
          sum_r[ch_q]  <= new_sum;
          new_sum_q    <= new_sum;
          ptr_r[ch_q]  <= ptr_r[ch_q] + DEPTH_LOG2'(1);
          fill_r[ch_q] <= fill_next;
          if (emit_due)               hop_r[ch_q] <= '0;
          else if (fill_next == DEPTH) hop_r[ch_q] <= hop_r[ch_q] + FILL_W'(1);
        end
        default: ;
      endcase
      if (state == EMIT && slot_free) begin
        energy_data      <= over ? '1 : wide_val[ENERGY_WIDTH-1:0];
        energy_saturated <= over;
        energy_channel   <= ch_q;
        energy_valid     <= 1'b1;
      end else if (energy_ready) begin
        energy_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == SQUARE) old_q <= ram[ram_addr];
    if (state == UPDATE) ram[ram_addr] <= sq_q;
  end

endmodule

// File: tb/tb_multichannel_window_energy.sv
// Directed plus random bench for multichannel_window_energy: a window-recompute model
// feeds an expected queue that is checked whenever a result is handed off downstream.
module tb_multichannel_window_energy;

  localparam int SW    = 16;
  localparam int EW    = 32;
  localparam int NCH   = 3;
  localparam int HOP   = 2;
  localparam int BIAS  = -32;
  localparam int EXP_W = 68;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic [1:0]    sample_channel = '0;
  logic          sample_valid = 1'b0;
  logic          energy_ready = 1'b1;
  int            ready_mode = 1;

  logic          sample_ready_a, energy_saturated_a, energy_valid_a;
  logic [EW-1:0] energy_data_a;
  logic [1:0]    energy_channel_a, debug_state_a;
  logic          sample_ready_b, energy_saturated_b, energy_valid_b;
  logic [EW-1:0] energy_data_b;
  logic [1:0]    energy_channel_b, debug_state_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected entry: {channel[2], sat, sum[32], mean_sat, mean[32]}.
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e, bp_e;
  longint unsigned  hist [NCH][4];
  int               cnt  [NCH];

  multichannel_window_energy #(
    .SAMPLE_WIDTH(SW), .ENERGY_WIDTH(EW), .CHANNELS(NCH), .DEPTH_LOG2(2),
    .HOP(HOP), .SIGNAL_BIAS(BIAS), .MEAN_MODE(0)
  ) dut_sum (
    .clock(clock), .resetn(resetn), .sample_data(sample_data),
    .sample_channel(sample_channel), .sample_valid(sample_valid),
    .sample_ready(sample_ready_a), .energy_data(energy_data_a),
    .energy_channel(energy_channel_a), .energy_saturated(energy_saturated_a),
    .energy_valid(energy_valid_a), .energy_ready(energy_ready),
    .debug_state(debug_state_a)
  );

  multichannel_window_energy #(
    .SAMPLE_WIDTH(SW), .ENERGY_WIDTH(EW), .CHANNELS(NCH), .DEPTH_LOG2(2),
    .HOP(HOP), .SIGNAL_BIAS(BIAS), .MEAN_MODE(1)
  ) dut_mean (
    .clock(clock), .resetn(resetn), .sample_data(sample_data),
    .sample_channel(sample_channel), .sample_valid(sample_valid),
    .sample_ready(sample_ready_b), .energy_data(energy_data_b),
    .energy_channel(energy_channel_b), .energy_saturated(energy_saturated_b),
    .energy_valid(energy_valid_b), .energy_ready(energy_ready),
    .debug_state(debug_state_b)
  );

  // Clock and downstream-ready generation
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    case (ready_mode)
      0:       energy_ready = 1'b0;
      1:       energy_ready = 1'b1;
      default: energy_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: keep the last four squares per channel and re-add them.
  task automatic model_accept(input int ch, input logic [SW-1:0] d);
    int b;
    longint unsigned s, m;
    logic [EXP_W-1:0] e;
    if (ch < NCH) begin
      b = int'($signed(d)) + BIAS;
      if (b > 32767)  b = 32767;
      if (b < -32768) b = -32768;
      hist[ch][cnt[ch] % 4] = longint'(b) * longint'(b);
      cnt[ch]++;
      if (cnt[ch] >= 4 && ((cnt[ch] - 4) % HOP) == 0) begin
        s = hist[ch][0] + hist[ch][1] + hist[ch][2] + hist[ch][3];
        m = s >> 2;
        e[67:66] = 2'(ch);
        e[65]    = s > 64'hFFFF_FFFF;
        e[64:33] = e[65] ? 32'hFFFF_FFFF : s[31:0];
        e[32]    = m > 64'hFFFF_FFFF;
        e[31:0]  = e[32] ? 32'hFFFF_FFFF : m[31:0];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
  endtask

  // Driver: hold valid until a ready edge, then record the sample in the model.
  task automatic send(input int ch, input int d);
    int n;
    sample_data    = SW'(d);
    sample_channel = 2'(ch);
    sample_valid   = 1'b1;
    n = 0;
    @(negedge clock);
    while (!sample_ready_a && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 64'(sample_ready_a), 1);
      sample_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      sample_valid = 1'b0;
      model_accept(ch, SW'(d));
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  // Scoreboard: compare each result at the edge where it is handed off.
  always @(negedge clock) begin
    if (resetn && energy_valid_a && energy_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(energy_valid_a), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("energy_channel", 64'(energy_channel_a), 64'(mon_e[67:66]));
        chk("energy_saturated", 64'(energy_saturated_a), 64'(mon_e[65]));
        chk("energy_data", 64'(energy_data_a), 64'(mon_e[64:33]));
        chk("mean_valid", 64'(energy_valid_b), 1);
        chk("mean_channel", 64'(energy_channel_b), 64'(mon_e[67:66]));
        chk("mean_saturated", 64'(energy_saturated_b), 64'(mon_e[32]));
        chk("mean_data", 64'(energy_data_b), 64'(mon_e[31:0]));
      end
    end
  end

  initial begin
    int lat, k;
    logic [EW-1:0] held;
    model_reset();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_energy_valid", 64'(energy_valid_a), 0);
    chk("rst_energy_data", 64'(energy_data_a), 0);
    chk("rst_energy_channel", 64'(energy_channel_a), 0);
    chk("rst_energy_saturated", 64'(energy_saturated_a), 0);
    chk("rst_sample_ready", 64'(sample_ready_a), 0);
    chk("rst_state", 64'(debug_state_a), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_reset", 64'(sample_ready_a), 1);

    // Warm-up and latency: biased 1,2,3,4 -> 30 three edges after the 4th accept
    send(0, 33); send(0, 34); send(0, 35); send(0, 36);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!energy_valid_a && lat < 20);
    chk("latency", 64'(lat), 3);
    chk("first_value", 64'(energy_data_a), 30);
    chk("first_channel", 64'(energy_channel_a), 0);
    send(0, 37); send(0, 38);
    wait_drain(50);

    // Zero-energy window, then bias-only energy on channel 1
    for (int i = 0; i < 4; i++) send(1, 32);
    for (int i = 0; i < 4; i++) send(1, 0);
    wait_drain(50);

    // Interleaved channels
    for (int i = 0; i < 4; i++) begin
      send(2, 40);
      send(0, 32 + i);
    end
    wait_drain(50);

    // Out-of-range channel is dropped with a single ready-low cycle
    send(3, 1234);
    chk("drop_ready_low", 64'(sample_ready_a), 0);
    chk("drop_state_idle", 64'(debug_state_a), 0);
    @(posedge clock);
    #1;
    chk("drop_ready_back", 64'(sample_ready_a), 1);
    repeat (6) @(posedge clock);
    #1;
    chk("drop_no_output", 64'(energy_valid_a), 0);

    // Full-scale negative samples saturate before squaring and in the sum
    for (int i = 0; i < 4; i++) send(2, 32'h8000);
    wait_drain(50);

    // Backpressure: one result held, a second blocked in EMIT
    ready_mode = 0;
    k = 0;
    while (exp_q.size() < 2 && k < 8) begin
      send(0, $urandom_range(0, 65535));
      k++;
    end
    repeat (3) @(posedge clock);
    #1;
    bp_e = exp_q[0];
    held = bp_e[64:33];
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 64'(energy_valid_a), 1);
      chk("bp_data_stable", 64'(energy_data_a), 64'(held));
      chk("bp_sample_ready", 64'(sample_ready_a), 0);
      @(posedge clock);
      #1;
    end
    ready_mode = 1;
    send(1, 100);
    wait_drain(50);

    // Random traffic with random downstream stalls
    ready_mode = 2;
    for (int i = 0; i < 60; i++) send($urandom_range(0, 3), $urandom_range(0, 65535));
    ready_mode = 1;
    wait_drain(200);

    // Reset while a result is pending and another sample is in SQUARE
    ready_mode = 0;
    k = 0;
    while (exp_q.size() < 1 && k < 8) begin
      send(1, $urandom_range(0, 65535));
      k++;
    end
    repeat (3) @(posedge clock);
    #1;
    send(2, 500);
    chk("pre_reset_square", 64'(debug_state_a), 1);
    resetn = 1'b0;
    #1;
    chk("midrst_energy_valid", 64'(energy_valid_a), 0);
    chk("midrst_energy_data", 64'(energy_data_a), 0);
    chk("midrst_energy_channel", 64'(energy_channel_a), 0);
    chk("midrst_energy_saturated", 64'(energy_saturated_a), 0);
    chk("midrst_sample_ready", 64'(sample_ready_a), 0);
    chk("midrst_state", 64'(debug_state_a), 0);
    model_reset();
    ready_mode = 1;
    @(negedge clock);
    resetn = 1'b1;

    // Warm-up restarts: three fresh samples give nothing, the fourth emits
    send(0, 40); send(0, 41); send(0, 42);
    repeat (8) @(posedge clock);
    #1;
    chk("rewarm_no_output", 64'(energy_valid_a), 0);
    send(0, 43);
    wait_drain(50);

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
